// File: rtl/arp_pkg.sv
// Shared ARP constants, frame-source tags and the header field bundle
// used by the ARP transmit scheduler.
package arp_pkg;

    localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'd1;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [47:0] MAC_BCAST        = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SRC_REPLY,
        SRC_REQ,
        SRC_GRAT
    } frame_src_e;

    typedef struct packed {
        logic [47:0] eth_dest;
        logic [47:0] eth_src;
        logic [15:0] eth_type;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_frame_t;

    function automatic arp_frame_t arp_build(
        input logic [15:0] oper,
        input logic [47:0] mac,
        input logic [31:0] ip,
        input logic [47:0] dest,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        arp_frame_t f;
        f.eth_dest = dest;
        f.eth_src  = mac;
        f.eth_type = ETHERTYPE_ARP;
        f.htype    = ARP_HTYPE_ETH;
        f.ptype    = ARP_PTYPE_IPV4;
        f.oper     = oper;
        f.sha      = mac;
        f.spa      = ip;
        f.tha      = tha;
        f.tpa      = tpa;
        return f;
    endfunction

endpackage

// File: rtl/arp_resolve_retry.sv
// Resolve engine: one outstanding cache-miss lookup, sending request
// frames at a fixed interval until answered or the attempts run out.
module arp_resolve_retry
    import arp_pkg::*;
#(
    parameter int RETRY_COUNT    = 4,
    parameter int RETRY_INTERVAL = 125000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        query_valid,
    output logic        query_ready,
    input  logic [31:0] query_ip,
    input  logic        query_done,
    output logic        query_fail,
    output logic        req_pend,
    output logic [31:0] req_ip,
    output logic        req_active,
    input  logic        req_sent
);

    localparam int AW = $clog2(RETRY_COUNT + 1);
    localparam int TW = $clog2(RETRY_INTERVAL);
    localparam logic [AW-1:0] MAX_ATT    = AW'(RETRY_COUNT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(RETRY_INTERVAL - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_SEND,
        R_WAIT
    } rstate_e;

    rstate_e        state_q;
    logic [31:0]    ip_q;
    logic [AW-1:0]  att_q;
    logic [TW-1:0]  timer_q;
    logic           fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= R_IDLE;
            ip_q    <= '0;
            att_q   <= '0;
            timer_q <= '0;
            fail_q  <= 1'b0;
        end else begin
            fail_q <= 1'b0;
            unique case (state_q)
                R_IDLE: begin
                    if (query_valid) begin
                        ip_q    <= query_ip;
                        att_q   <= '0;
                        timer_q <= '0;
                        state_q <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (query_done) begin
                        state_q <= R_IDLE;
                    end else if (req_sent) begin
                        att_q   <= att_q + 1'b1;
                        timer_q <= TIMER_LOAD;
                        state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // an answer arriving on the expiry cycle beats the failure
                    if (query_done) begin
                        state_q <= R_IDLE;
                    end else if (timer_q == '0) begin
                        if (att_q == MAX_ATT) begin
                            fail_q  <= 1'b1;
                            state_q <= R_IDLE;
                        end else begin
                            state_q <= R_SEND;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign query_ready = (state_q == R_IDLE);
    assign query_fail  = fail_q;
    assign req_pend    = (state_q == R_SEND);
    assign req_ip      = ip_q;
    assign req_active  = (state_q != R_IDLE);

endmodule

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: arbitrates reply, resolve-request and
// gratuitous frames onto one valid/ready header-field interface.
module arp_tx_sched
    import arp_pkg::*;
#(
    parameter int RETRY_COUNT    = 4,
    parameter int RETRY_INTERVAL = 125000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        reply_valid,
    output logic        reply_ready,
    input  logic [47:0] reply_tha,
    input  logic [31:0] reply_tpa,
    input  logic        query_valid,
    output logic        query_ready,
    input  logic [31:0] query_ip,
    input  logic        query_done,
    output logic        query_fail,
    input  logic        grat_trigger,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [15:0] m_arp_htype,
    output logic [15:0] m_arp_ptype,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [31:0] m_arp_spa,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_tpa,
    output logic        busy
);

    typedef enum logic {
        F_IDLE,
        F_SEND
    } fstate_e;

    fstate_e     fstate_q;
    frame_src_e  src_q;
    arp_frame_t  frame_q;
    logic        valid_q;
    logic        reply_pend_q;
    logic [47:0] reply_tha_q;
    logic [31:0] reply_tpa_q;
    logic        grat_pend_q;

    logic        req_pend;
    logic [31:0] req_ip;
    logic        req_active;
    logic        req_sent;

    assign req_sent = valid_q && m_frame_ready && (src_q == SRC_REQ);

    arp_resolve_retry #(
        .RETRY_COUNT    (RETRY_COUNT),
        .RETRY_INTERVAL (RETRY_INTERVAL)
    ) u_resolve (
        .clk         (clk),
        .rst         (rst),
        .query_valid (query_valid),
        .query_ready (query_ready),
        .query_ip    (query_ip),
        .query_done  (query_done),
        .query_fail  (query_fail),
        .req_pend    (req_pend),
        .req_ip      (req_ip),
        .req_active  (req_active),
        .req_sent    (req_sent)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate_q     <= F_IDLE;
            src_q        <= SRC_REPLY;
            frame_q      <= '0;
            valid_q      <= 1'b0;
            reply_pend_q <= 1'b0;
            reply_tha_q  <= '0;
            reply_tpa_q  <= '0;
            grat_pend_q  <= 1'b0;
        end else begin
            if (reply_valid && !reply_pend_q) begin
                reply_pend_q <= 1'b1;
                reply_tha_q  <= reply_tha;
                reply_tpa_q  <= reply_tpa;
            end
            unique case (fstate_q)
                F_IDLE: begin
                    if (reply_pend_q) begin
                        frame_q  <= arp_build(ARP_OPER_REPLY, local_mac,
                                              local_ip, reply_tha_q,
                                              reply_tha_q, reply_tpa_q);
                        src_q    <= SRC_REPLY;
                        valid_q  <= 1'b1;
                        fstate_q <= F_SEND;
                    end else if (req_pend) begin
                        frame_q  <= arp_build(ARP_OPER_REQUEST, local_mac,
                                              local_ip, MAC_BCAST,
                                              48'd0, req_ip);
                        src_q    <= SRC_REQ;
                        valid_q  <= 1'b1;
                        fstate_q <= F_SEND;
                    end else if (grat_pend_q) begin
                        frame_q  <= arp_build(ARP_OPER_REQUEST, local_mac,
                                              local_ip, MAC_BCAST,
                                              48'd0, local_ip);
                        src_q    <= SRC_GRAT;
                        valid_q  <= 1'b1;
                        fstate_q <= F_SEND;
                    end
                end
                F_SEND: begin
                    if (m_frame_ready) begin
                        valid_q  <= 1'b0;
                        fstate_q <= F_IDLE;
                        if (src_q == SRC_REPLY) reply_pend_q <= 1'b0;
                        if (src_q == SRC_GRAT)  grat_pend_q  <= 1'b0;
                    end
                end
                default: fstate_q <= F_IDLE;
            endcase
            // a trigger on the handshake cycle starts a fresh announcement
            if (grat_trigger) grat_pend_q <= 1'b1;
        end
    end

    assign reply_ready    = !reply_pend_q;
    assign busy           = reply_pend_q | grat_pend_q | req_active | valid_q;
    assign m_frame_valid  = valid_q;
    assign m_eth_dest_mac = frame_q.eth_dest;
    assign m_eth_src_mac  = frame_q.eth_src;
    assign m_eth_type     = frame_q.eth_type;
    assign m_arp_htype    = frame_q.htype;
    assign m_arp_ptype    = frame_q.ptype;
    assign m_arp_oper     = frame_q.oper;
    assign m_arp_sha      = frame_q.sha;
    assign m_arp_spa      = frame_q.spa;
    assign m_arp_tha      = frame_q.tha;
    assign m_arp_tpa      = frame_q.tpa;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Directed bench for arp_tx_sched with short retry settings.
module tb_arp_tx_sched;

    localparam logic [47:0] LMAC  = 48'h02_11_22_33_44_55;
    localparam logic [31:0] LIP   = 32'h0A00_0001;
    localparam logic [47:0] RTHA  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] RTPA  = 32'h0A00_0002;
    localparam logic [31:0] QIP   = 32'h0A00_0009;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        reply_valid;
    logic        reply_ready;
    logic [47:0] reply_tha;
    logic [31:0] reply_tpa;
    logic        query_valid;
    logic        query_ready;
    logic [31:0] query_ip;
    logic        query_done;
    logic        query_fail;
    logic        grat_trigger;
    logic        m_frame_valid;
    logic        m_frame_ready;
    logic [47:0] m_eth_dest_mac;
    logic [47:0] m_eth_src_mac;
    logic [15:0] m_eth_type;
    logic [15:0] m_arp_htype;
    logic [15:0] m_arp_ptype;
    logic [15:0] m_arp_oper;
    logic [47:0] m_arp_sha;
    logic [31:0] m_arp_spa;
    logic [47:0] m_arp_tha;
    logic [31:0] m_arp_tpa;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int nfr;
    int nfail;
    int ngrat;
    int last;

    arp_tx_sched #(
        .RETRY_COUNT    (3),
        .RETRY_INTERVAL (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .local_mac      (local_mac),
        .local_ip       (local_ip),
        .reply_valid    (reply_valid),
        .reply_ready    (reply_ready),
        .reply_tha      (reply_tha),
        .reply_tpa      (reply_tpa),
        .query_valid    (query_valid),
        .query_ready    (query_ready),
        .query_ip       (query_ip),
        .query_done     (query_done),
        .query_fail     (query_fail),
        .grat_trigger   (grat_trigger),
        .m_frame_valid  (m_frame_valid),
        .m_frame_ready  (m_frame_ready),
        .m_eth_dest_mac (m_eth_dest_mac),
        .m_eth_src_mac  (m_eth_src_mac),
        .m_eth_type     (m_eth_type),
        .m_arp_htype    (m_arp_htype),
        .m_arp_ptype    (m_arp_ptype),
        .m_arp_oper     (m_arp_oper),
        .m_arp_sha      (m_arp_sha),
        .m_arp_spa      (m_arp_spa),
        .m_arp_tha      (m_arp_tha),
        .m_arp_tpa      (m_arp_tpa),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        local_mac = LMAC;
        local_ip = LIP;
        reply_valid = 1'b0;
        reply_tha = '0;
        reply_tpa = '0;
        query_valid = 1'b0;
        query_ip = '0;
        query_done = 1'b0;
        grat_trigger = 1'b0;
        m_frame_ready = 1'b1;
        step();
        step();
        chk("rst_valid", m_frame_valid, 0);
        chk("rst_reply_ready", reply_ready, 1);
        chk("rst_query_ready", query_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fail", query_fail, 0);
        chk("rst_oper", m_arp_oper, 0);
        chk("rst_dest", m_eth_dest_mac, 0);
        rst = 1'b0;
        step();

        // 1: single reply
        reply_valid = 1'b1;
        reply_tha = RTHA;
        reply_tpa = RTPA;
        step();
        reply_valid = 1'b0;
        chk("t1_reply_ready", reply_ready, 0);
        chk("t1_valid_early", m_frame_valid, 0);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_valid", m_frame_valid, 1);
        chk("t1_oper", m_arp_oper, 2);
        chk("t1_dest", m_eth_dest_mac, RTHA);
        chk("t1_src", m_eth_src_mac, LMAC);
        chk("t1_type", m_eth_type, 16'h0806);
        chk("t1_htype", m_arp_htype, 1);
        chk("t1_ptype", m_arp_ptype, 16'h0800);
        chk("t1_sha", m_arp_sha, LMAC);
        chk("t1_spa", m_arp_spa, LIP);
        chk("t1_tha", m_arp_tha, RTHA);
        chk("t1_tpa", m_arp_tpa, RTPA);
        step();
        chk("t1_valid_after", m_frame_valid, 0);
        chk("t1_reply_ready_after", reply_ready, 1);
        chk("t1_busy_after", busy, 0);

        // 2: resolve with no answer
        query_valid = 1'b1;
        query_ip = QIP;
        step();
        query_valid = 1'b0;
        chk("t2_query_ready", query_ready, 0);
        nfr = 0;
        nfail = 0;
        last = -1;
        for (int c = 0; c < 90; c++) begin
            if (m_frame_valid && m_frame_ready) begin
                chk("t2_oper", m_arp_oper, 1);
                chk("t2_dest", m_eth_dest_mac, BCAST);
                chk("t2_tha", m_arp_tha, 0);
                chk("t2_tpa", m_arp_tpa, QIP);
                if (last >= 0) chk("t2_gap", 64'(c - last), 18);
                last = c;
                nfr++;
            end
            if (query_fail) nfail++;
            step();
        end
        chk("t2_frames", 64'(nfr), 3);
        chk("t2_fail_pulses", 64'(nfail), 1);
        chk("t2_query_ready_end", query_ready, 1);
        chk("t2_busy_end", busy, 0);

        // 3a: answered after first request
        query_valid = 1'b1;
        query_ip = QIP;
        step();
        query_valid = 1'b0;
        for (int c = 0; c < 5 && !m_frame_valid; c++) step();
        chk("t3a_first", m_frame_valid, 1);
        step();
        repeat (3) step();
        query_done = 1'b1;
        step();
        query_done = 1'b0;
        nfr = 0;
        nfail = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_frame_valid) nfr++;
            if (query_fail) nfail++;
            step();
        end
        chk("t3a_frames", 64'(nfr), 0);
        chk("t3a_fail", 64'(nfail), 0);
        chk("t3a_query_ready", query_ready, 1);

        // 3b: answer lands on the final expiry cycle
        query_valid = 1'b1;
        query_ip = QIP;
        step();
        query_valid = 1'b0;
        nfr = 0;
        for (int c = 0; c < 80; c++) begin
            if (m_frame_valid && m_frame_ready) begin
                nfr++;
                if (nfr == 3) break;
            end
            step();
        end
        chk("t3b_frames", 64'(nfr), 3);
        step();
        repeat (15) step();
        query_done = 1'b1;
        step();
        query_done = 1'b0;
        chk("t3b_fail", query_fail, 0);
        chk("t3b_query_ready", query_ready, 1);
        nfail = 0;
        repeat (20) begin
            if (query_fail) nfail++;
            step();
        end
        chk("t3b_fail_later", 64'(nfail), 0);

        // 4: all three requesters at once under backpressure
        m_frame_ready = 1'b0;
        reply_valid = 1'b1;
        reply_tha = RTHA;
        reply_tpa = RTPA;
        query_valid = 1'b1;
        query_ip = QIP;
        grat_trigger = 1'b1;
        step();
        reply_valid = 1'b0;
        query_valid = 1'b0;
        grat_trigger = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("t4_stall_valid", m_frame_valid, 1);
            chk("t4_stall_oper", m_arp_oper, 2);
            chk("t4_stall_dest", m_eth_dest_mac, RTHA);
            chk("t4_stall_tpa", m_arp_tpa, RTPA);
            if (c < 4) step();
        end
        m_frame_ready = 1'b1;
        step();
        chk("t4_gap1", m_frame_valid, 0);
        step();
        chk("t4_req_valid", m_frame_valid, 1);
        chk("t4_req_oper", m_arp_oper, 1);
        chk("t4_req_dest", m_eth_dest_mac, BCAST);
        chk("t4_req_tpa", m_arp_tpa, QIP);
        step();
        chk("t4_gap2", m_frame_valid, 0);
        step();
        chk("t4_grat_valid", m_frame_valid, 1);
        chk("t4_grat_oper", m_arp_oper, 1);
        chk("t4_grat_tha", m_arp_tha, 0);
        chk("t4_grat_tpa", m_arp_tpa, LIP);
        step();
        query_done = 1'b1;
        step();
        query_done = 1'b0;
        chk("t4_busy_end", busy, 0);

        // 5: repeated gratuitous triggers merge while a reply stalls
        m_frame_ready = 1'b0;
        reply_valid = 1'b1;
        step();
        reply_valid = 1'b0;
        step();
        repeat (3) begin
            grat_trigger = 1'b1;
            step();
            grat_trigger = 1'b0;
            step();
        end
        m_frame_ready = 1'b1;
        nfr = 0;
        ngrat = 0;
        for (int c = 0; c < 15; c++) begin
            if (m_frame_valid) begin
                nfr++;
                if (m_arp_oper == 16'd1 && m_arp_tpa == LIP) ngrat++;
            end
            step();
        end
        chk("t5_frames", 64'(nfr), 2);
        chk("t5_grat_frames", 64'(ngrat), 1);

        // 6: reset while a frame is stalled
        m_frame_ready = 1'b0;
        reply_valid = 1'b1;
        query_valid = 1'b1;
        step();
        reply_valid = 1'b0;
        query_valid = 1'b0;
        step();
        chk("t6_pre_valid", m_frame_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", m_frame_valid, 0);
        step();
        rst = 1'b0;
        step();
        chk("t6_reply_ready", reply_ready, 1);
        chk("t6_query_ready", query_ready, 1);
        chk("t6_busy", busy, 0);
        m_frame_ready = 1'b1;
        nfr = 0;
        repeat (6) begin
            if (m_frame_valid) nfr++;
            step();
        end
        chk("t6_no_frame", 64'(nfr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
